// File: rtl/mips_alu_decode.sv
// mips_alu_decode: single-entry decode stage between fetch and execute.
// Turns a 32-bit MIPS instruction into a one-hot ALU op, shift amount,
// register indices, extended immediate and write-back controls.
// Optional feature macro: ALU_DECODE_TRAP_EN (drives illegal=1 on
// unsupported encodings; when undefined illegal is tied low).
module mips_alu_decode #(
    parameter int              OP_W     = 11,
    parameter logic [OP_W-1:0] RESET_OP = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] alu_op,
    output logic [4:0]      sa,
    output logic [4:0]      rs_idx,
    output logic [4:0]      rt_idx,
    output logic [4:0]      dest_idx,
    output logic [31:0]     imm32,
    output logic            b_sel_imm,
    output logic            reg_write,
    output logic            illegal
);

    // One-hot ALU operation encodings (bit position is the operation)
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1) << 0;
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(1) << 1;
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(1) << 2;
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(1) << 3;
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(1) << 4;
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1) << 5;
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(1) << 6;
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(1) << 7;
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(1) << 8;
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(1) << 9;
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(1) << 10;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;

    logic [OP_W-1:0] alu_op_next;
    logic [4:0]      sa_next;
    logic [4:0]      dest_next;
    logic [31:0]     imm_next;
    logic            b_sel_next;
    logic            legal_next;
    logic            reg_write_next;

    logic            out_valid_reg;
    logic [OP_W-1:0] alu_op_reg;
    logic [4:0]      sa_reg;
    logic [4:0]      rs_reg;
    logic [4:0]      rt_reg;
    logic [4:0]      dest_reg;
    logic [31:0]     imm_reg;
    logic            b_sel_reg;
    logic            reg_write_reg;

    logic            load;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    // Stage can take a new instruction when empty or when the held one leaves
    assign in_ready = !out_valid_reg || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Combinational decode of the incoming instruction word
    always_comb begin
        alu_op_next = RESET_OP;
        sa_next     = '0;
        dest_next   = '0;
        imm_next    = '0;
        b_sel_next  = 1'b0;
        legal_next  = 1'b1;
        if (opcode == 6'h00) begin
            dest_next = instr[15:11];
            case (funct)
                6'h20, 6'h21: alu_op_next = OP_ADD;
                6'h22, 6'h23: alu_op_next = OP_SUB;
                6'h24:        alu_op_next = OP_AND;
                6'h25:        alu_op_next = OP_OR;
                6'h26:        alu_op_next = OP_XOR;
                6'h27:        alu_op_next = OP_NOR;
                6'h2A:        alu_op_next = OP_SLT;
                6'h2B:        alu_op_next = OP_SLTU;
                6'h00: begin alu_op_next = OP_SLL; sa_next = instr[10:6]; end
                6'h02: begin alu_op_next = OP_SRL; sa_next = instr[10:6]; end
                6'h03: begin alu_op_next = OP_SRA; sa_next = instr[10:6]; end
                default:      legal_next  = 1'b0;
            endcase
        end else begin
            dest_next  = instr[20:16];
            b_sel_next = 1'b1;
            case (opcode)
                6'h08, 6'h09: begin alu_op_next = OP_ADD;  imm_next = {{16{imm16[15]}}, imm16}; end
                6'h0A:        begin alu_op_next = OP_SLT;  imm_next = {{16{imm16[15]}}, imm16}; end
                6'h0B:        begin alu_op_next = OP_SLTU; imm_next = {{16{imm16[15]}}, imm16}; end
                6'h0C:        begin alu_op_next = OP_AND;  imm_next = {16'h0000, imm16}; end
                6'h0D:        begin alu_op_next = OP_OR;   imm_next = {16'h0000, imm16}; end
                6'h0E:        begin alu_op_next = OP_XOR;  imm_next = {16'h0000, imm16}; end
                6'h0F: begin
                    // LUI is executed as the immediate shifted left by 16
                    alu_op_next = OP_SLL;
                    imm_next    = {16'h0000, imm16};
                    sa_next     = 5'd16;
                end
                default:      legal_next = 1'b0;
            endcase
        end
        if (!legal_next) begin
            alu_op_next = RESET_OP;
            sa_next     = '0;
            dest_next   = '0;
            imm_next    = '0;
            b_sel_next  = 1'b0;
        end
        reg_write_next = legal_next && (dest_next != 5'd0);
    end

    // Pipeline register: flush drops everything, otherwise load or drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            alu_op_reg    <= RESET_OP;
            sa_reg        <= '0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            dest_reg      <= '0;
            imm_reg       <= '0;
            b_sel_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            alu_op_reg    <= alu_op_next;
            sa_reg        <= sa_next;
            rs_reg        <= instr[25:21];
            rt_reg        <= instr[20:16];
            dest_reg      <= dest_next;
            imm_reg       <= imm_next;
            b_sel_reg     <= b_sel_next;
            reg_write_reg <= reg_write_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef ALU_DECODE_TRAP_EN
    logic illegal_reg;

    // Trap flag travels with the beat it belongs to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_reg <= 1'b0;
        end else if (!flush && load) begin
            illegal_reg <= !legal_next;
        end
    end
    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    // alu_op reads as RESET_OP whenever no beat is presented
    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_op_gate
            assign alu_op[gi] = out_valid_reg ? alu_op_reg[gi] : RESET_OP[gi];
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign sa        = sa_reg;
    assign rs_idx    = rs_reg;
    assign rt_idx    = rt_reg;
    assign dest_idx  = dest_reg;
    assign imm32     = imm_reg;
    assign b_sel_imm = b_sel_reg;
    assign reg_write = reg_write_reg;

endmodule

// File: tb/tb_mips_alu_decode.sv
// Directed bench for mips_alu_decode: reset, R/I-type decode, stall,
// flush and unsupported encodings, with hand-computed expectations.
module tb_mips_alu_decode;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] alu_op;
    logic [4:0]  sa;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  dest_idx;
    logic [31:0] imm32;
    logic        b_sel_imm;
    logic        reg_write;
    logic        illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    mips_alu_decode dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .sa        (sa),
        .rs_idx    (rs_idx),
        .rt_idx    (rt_idx),
        .dest_idx  (dest_idx),
        .imm32     (imm32),
        .b_sel_imm (b_sel_imm),
        .reg_write (reg_write),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge, then withdraw it
    task automatic issue(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        step();
        in_valid = 1'b0;
        instr    = 32'h0;
    endtask

    task automatic chk_beat(input string tag, input logic [10:0] op, input logic [4:0] d,
                            input logic [31:0] imm, input logic [4:0] s,
                            input logic bs, input logic rw);
        $display("beat %s: op=%h dest=%0d imm=%h sa=%0d bsel=%0d rw=%0d",
                 tag, alu_op, dest_idx, imm32, sa, b_sel_imm, reg_write);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".op"},    alu_op,    op);
        chk({tag, ".dest"},  dest_idx,  d);
        chk({tag, ".imm"},   imm32,     imm);
        chk({tag, ".sa"},    sa,        s);
        chk({tag, ".bsel"},  b_sel_imm, bs);
        chk({tag, ".rw"},    reg_write, rw);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        out_ready = 1'b1;
        #1;
        chk("rst.valid", out_valid, 0);
        chk("rst.op", alu_op, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rst.in_ready", in_ready, 1);

        // ADDU $3,$1,$2
        issue(32'h00221821);
        chk_beat("addu", 11'h001, 5'd3, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("addu.rs", rs_idx, 1);
        chk("addu.rt", rt_idx, 2);

        // Consume without accept empties the stage
        step();
        chk("drain.valid", out_valid, 0);
        chk("drain.op", alu_op, 0);

        issue(32'h3C051234);
        chk_beat("lui", 11'h400, 5'd5, 32'h00001234, 5'd16, 1'b1, 1'b1);
        issue(32'h20048000);
        chk_beat("addi", 11'h001, 5'd4, 32'hFFFF8000, 5'd0, 1'b1, 1'b1);
        issue(32'h34048000);
        chk_beat("ori", 11'h008, 5'd4, 32'h00008000, 5'd0, 1'b1, 1'b1);
        issue(32'h00023943);
        chk_beat("sra", 11'h100, 5'd7, 32'h0, 5'd5, 1'b0, 1'b1);
        issue(32'h0022182A);
        chk_beat("slt", 11'h080, 5'd3, 32'h0, 5'd0, 1'b0, 1'b1);
        issue(32'h00221827);
        chk_beat("nor", 11'h010, 5'd3, 32'h0, 5'd0, 1'b0, 1'b1);
        issue(32'h3004FFFF);
        chk_beat("andi", 11'h002, 5'd4, 32'h0000FFFF, 5'd0, 1'b1, 1'b1);
        issue(32'h2800FFFF);
        chk_beat("slti_r0", 11'h080, 5'd0, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0);
        issue(32'h00000000);
        chk_beat("nop", 11'h400, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0);

        // Unsupported opcode
        issue(32'hFC000000);
        chk_beat("ill", 11'h000, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0);
`ifdef ALU_DECODE_TRAP_EN
        chk("ill.flag", illegal, 1);
`else
        chk("ill.flag", illegal, 0);
`endif
        issue(32'h00221822);
        chk_beat("sub", 11'h020, 5'd3, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("sub.noflag", illegal, 0);

        // Stall: A held while B waits, then B,C,D at full rate
        step();
        issue(32'h00221821);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h3C051234;
        #1;
        chk("stall.in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.valid", out_valid, 1);
            chk("stall.op", alu_op, 11'h001);
            chk("stall.dest", dest_idx, 3);
            chk("stall.in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", in_ready, 1);
        step();
        chk_beat("strmB", 11'h400, 5'd5, 32'h00001234, 5'd16, 1'b1, 1'b1);
        instr = 32'h34048000;
        step();
        chk_beat("strmC", 11'h008, 5'd4, 32'h00008000, 5'd0, 1'b1, 1'b1);
        instr = 32'h00223022;
        step();
        chk_beat("strmD", 11'h020, 5'd6, 32'h0, 5'd0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step();
        chk("strm.end", out_valid, 0);

        // Flush with both an incoming and a held instruction
        issue(32'h00221821);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h34048000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.valid", out_valid, 0);
        chk("flush.op", alu_op, 0);
        step();
        chk("flush.gone", out_valid, 0);
        out_ready = 1'b1;

        // Async reset while stalled with a held beat
        issue(32'h00221821);
        out_ready = 1'b0;
        step();
        chk("pre_rst.valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.valid", out_valid, 0);
        chk("arst.op", alu_op, 0);
        chk("arst.dest", dest_idx, 0);
        chk("arst.rw", reg_write, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("arst.in_ready", in_ready, 1);
        chk("arst.valid2", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
